// File: rtl/lives_manager_pkg.sv
// lives_manager_pkg: shared game-state types and default life/score constants.
// Used by lives_manager, the HUD renderer and the game-control FSM.
// No ports; types, constants and a width helper only.
package lives_manager_pkg;

  typedef enum logic [1:0] {
    LS_PLAY      = 2'd0,
    LS_DYING     = 2'd1,
    LS_INVULN    = 2'd2,
    LS_GAME_OVER = 2'd3
  } life_state_t;

  localparam int DEF_START_LIVES = 3;
  localparam int DEF_MAX_LIVES   = 5;
  localparam int DEF_BONUS_SCORE = 10000;

  // Counter width able to hold the larger of two tick limits.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lives_manager_tick_timer.sv
// tick_timer: counts tick strobes up to a runtime limit; o_done marks the final tick.
// Ports: i_clk, i_reset (sync, high), i_clear (zero the count), i_tick, i_limit;
//        o_done is high in the cycle whose tick completes the limit.
module tick_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Combinational so the owner can change state on the very edge that
  // samples the last tick.
  assign o_done = i_tick && (r_count == i_limit - CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_tick && !o_done) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lives_manager.sv
// lives_manager: lives count, lethal/edible collision edges, death and
// invulnerability sequencing, one-shot score bonus, sticky game-over.
// Ports: i_clk, i_reset (sync, high), i_tick, i_collide, i_frightened, i_score;
//        o_lives_out, o_dying, o_respawn, o_invuln, o_ghost_eaten, o_lost, o_bonus_done.
module lives_manager
  import lives_manager_pkg::*;
#(
  parameter int LIVES_W      = 4,
  parameter int START_LIVES  = DEF_START_LIVES,
  parameter int MAX_LIVES    = DEF_MAX_LIVES,
  parameter int NUM_GHOSTS   = 4,
  parameter int SCORE_W      = 16,
  parameter int BONUS_SCORE  = DEF_BONUS_SCORE,
  parameter int DEATH_TICKS  = 90,
  parameter int INVULN_TICKS = 120
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic [NUM_GHOSTS-1:0] i_collide,
  input  logic [NUM_GHOSTS-1:0] i_frightened,
  input  logic [SCORE_W-1:0]    i_score,
  output logic [LIVES_W-1:0]    o_lives_out,
  output logic                  o_dying,
  output logic                  o_respawn,
  output logic                  o_invuln,
  output logic [NUM_GHOSTS-1:0] o_ghost_eaten,
  output logic                  o_lost,
  output logic                  o_bonus_done
);

  localparam int CNT_W = timer_width(DEATH_TICKS, INVULN_TICKS);

  if (START_LIVES < 1 || START_LIVES > MAX_LIVES || MAX_LIVES >= (1 << LIVES_W)) begin : g_bad_params
    $error("lives_manager: need 1 <= START_LIVES <= MAX_LIVES < 2**LIVES_W");
  end

  life_state_t           r_state, w_state_nxt;
  logic [LIVES_W-1:0]    r_lives, w_lives_nxt;
  logic                  r_lethal_q;
  logic [NUM_GHOSTS-1:0] r_eat_q;
  logic                  r_bonus_done;
  logic                  r_dying, r_respawn, r_invuln, r_lost;
  logic [NUM_GHOSTS-1:0] r_ghost_eaten;

  logic                  w_lethal, w_death, w_bonus;
  logic [NUM_GHOSTS-1:0] w_eat_now, w_eat_edge;
  logic                  w_timer_clear, w_timer_done, w_respawn_nxt;
  logic [CNT_W-1:0]      w_limit;

  // Edge detection: a collision held across states never retriggers.
  assign w_lethal   = |(i_collide & ~i_frightened);
  assign w_eat_now  = i_collide & i_frightened;
  assign w_eat_edge = w_eat_now & ~r_eat_q;
  assign w_death    = (r_state == LS_PLAY) && w_lethal && !r_lethal_q;
  assign w_bonus    = !r_bonus_done && (i_score >= SCORE_W'(BONUS_SCORE))
                      && (r_state != LS_GAME_OVER);
  assign w_limit    = (r_state == LS_DYING) ? CNT_W'(DEATH_TICKS) : CNT_W'(INVULN_TICKS);

  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_timer_clear),
    .i_tick  (i_tick),
    .i_limit (w_limit),
    .o_done  (w_timer_done)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_respawn_nxt = 1'b0;
    w_timer_clear = 1'b0;
    case (r_state)
      LS_PLAY: begin
        // Held at zero so DYING starts counting from its first cycle.
        w_timer_clear = 1'b1;
        if (w_death) w_state_nxt = LS_DYING;
      end
      LS_DYING: begin
        if (w_timer_done) begin
          w_timer_clear = 1'b1;
          if (r_lives == '0) begin
            w_state_nxt = LS_GAME_OVER;
          end else begin
            w_state_nxt   = LS_INVULN;
            w_respawn_nxt = 1'b1;
          end
        end
      end
      LS_INVULN: begin
        if (w_timer_done) begin
          w_timer_clear = 1'b1;
          w_state_nxt   = LS_PLAY;
        end
      end
      LS_GAME_OVER: w_timer_clear = 1'b1;
      default: begin
        w_timer_clear = 1'b1;
        w_state_nxt   = LS_PLAY;
      end
    endcase
  end

  // Death and bonus in the same cycle cancel out.
  always_comb begin
    w_lives_nxt = r_lives;
    if (w_state_nxt == LS_GAME_OVER) begin
      w_lives_nxt = '0;
    end else if (w_death && !w_bonus) begin
      w_lives_nxt = r_lives - LIVES_W'(1);
    end else if (w_bonus && !w_death && (r_lives != LIVES_W'(MAX_LIVES))) begin
      w_lives_nxt = r_lives + LIVES_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= LS_PLAY;
      r_lives       <= LIVES_W'(START_LIVES);
      r_lethal_q    <= 1'b0;
      r_eat_q       <= '0;
      r_bonus_done  <= 1'b0;
      r_dying       <= 1'b0;
      r_respawn     <= 1'b0;
      r_invuln      <= 1'b0;
      r_lost        <= 1'b0;
      r_ghost_eaten <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_lives       <= w_lives_nxt;
      r_lethal_q    <= w_lethal;
      r_eat_q       <= w_eat_now;
      r_bonus_done  <= r_bonus_done | w_bonus;
      r_dying       <= (w_state_nxt == LS_DYING);
      r_respawn     <= w_respawn_nxt;
      r_invuln      <= (w_state_nxt == LS_INVULN);
      r_lost        <= (w_state_nxt == LS_GAME_OVER);
      r_ghost_eaten <= ((r_state == LS_PLAY) || (r_state == LS_INVULN)) ? w_eat_edge : '0;
    end
  end

  assign o_lives_out   = r_lives;
  assign o_dying       = r_dying;
  assign o_respawn     = r_respawn;
  assign o_invuln      = r_invuln;
  assign o_lost        = r_lost;
  assign o_ghost_eaten = r_ghost_eaten;
  assign o_bonus_done  = r_bonus_done;

endmodule

// File: tb/tb_lives_manager.sv
// tb_lives_manager: directed scenarios plus randomized play against a
// cycle-level behavioural model of lives, timers, bonus and game-over.
// Outputs are compared every cycle on the falling edge.
module tb_lives_manager;

  localparam int LW = 4;
  localparam int SL = 4;
  localparam int ML = 4;
  localparam int NG = 4;
  localparam int SW = 16;
  localparam int BS = 10000;
  localparam int DT = 90;
  localparam int IT = 120;

  localparam int M_PLAY = 0;
  localparam int M_DYING = 1;
  localparam int M_INV = 2;
  localparam int M_OVER = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [NG-1:0] collide;
  logic [NG-1:0] frightened;
  logic [SW-1:0] score;
  logic [LW-1:0] lives_out;
  logic          dying, respawn, invuln, lost, bonus_done;
  logic [NG-1:0] ghost_eaten;

  always #5 clk = ~clk;

  lives_manager #(
    .LIVES_W(LW), .START_LIVES(SL), .MAX_LIVES(ML), .NUM_GHOSTS(NG),
    .SCORE_W(SW), .BONUS_SCORE(BS), .DEATH_TICKS(DT), .INVULN_TICKS(IT)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_tick        (tick),
    .i_collide     (collide),
    .i_frightened  (frightened),
    .i_score       (score),
    .o_lives_out   (lives_out),
    .o_dying       (dying),
    .o_respawn     (respawn),
    .o_invuln      (invuln),
    .o_ghost_eaten (ghost_eaten),
    .o_lost        (lost),
    .o_bonus_done  (bonus_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int            m_mode, m_lives, m_ticks;
  bit            m_lethal_prev, m_bonus, e_resp;
  logic [NG-1:0] m_eat_prev, e_eaten;

  task automatic model_step();
    bit            lethal, trig, bonus;
    logic [NG-1:0] eat_now;
    int            old_lives;
    if (reset) begin
      m_mode = M_PLAY; m_lives = SL; m_ticks = 0;
      m_lethal_prev = 0; m_eat_prev = '0; m_bonus = 0;
      e_eaten = '0; e_resp = 0;
      return;
    end
    lethal  = |(collide & ~frightened);
    trig    = lethal && !m_lethal_prev;
    eat_now = collide & frightened;
    e_eaten = (m_mode == M_PLAY || m_mode == M_INV) ? (eat_now & ~m_eat_prev) : '0;
    e_resp  = 0;
    old_lives = m_lives;
    bonus = !m_bonus && (int'(score) >= BS) && (m_mode != M_OVER);
    if (bonus) m_bonus = 1;
    case (m_mode)
      M_PLAY: begin
        if (trig) begin
          m_lives = m_lives - 1;
          m_mode = M_DYING;
          m_ticks = 0;
        end
      end
      M_DYING: begin
        if (tick) begin
          m_ticks++;
          if (m_ticks == DT) begin
            m_ticks = 0;
            if (old_lives == 0) begin
              m_mode = M_OVER;
            end else begin
              m_mode = M_INV;
              e_resp = 1;
            end
          end
        end
      end
      M_INV: begin
        if (tick) begin
          m_ticks++;
          if (m_ticks == IT) begin
            m_ticks = 0;
            m_mode = M_PLAY;
          end
        end
      end
      default: ;
    endcase
    if (bonus) m_lives = (m_lives + 1 > ML) ? ML : m_lives + 1;
    if (m_mode == M_OVER) m_lives = 0;
    m_lethal_prev = lethal;
    m_eat_prev = eat_now;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("lives", 32'(lives_out), 32'(m_lives));
    chk("dying", 32'(dying), 32'(m_mode == M_DYING));
    chk("invuln", 32'(invuln), 32'(m_mode == M_INV));
    chk("lost", 32'(lost), 32'(m_mode == M_OVER));
    chk("respawn", 32'(respawn), 32'(e_resp));
    chk("ghost_eaten", 32'(ghost_eaten), 32'(e_eaten));
    chk("bonus_done", 32'(bonus_done), 32'(m_bonus));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic die_once();
    collide = 4'b0001; frightened = '0;
    step();
    collide = '0;
    run(DT + IT + 5);
  endtask

  initial begin
    int r;
    reset = 1'b1; tick = 1'b0; collide = '0; frightened = '0; score = '0;
    @(negedge clk);
    step();
    reset = 1'b0;
    tick = 1'b1;

    // Single lethal collision on ghost 2, full death/invuln cycle.
    collide = 4'b0100; step();
    collide = '0; run(DT + IT + 5);

    // Collision held through DYING and INVULN back into PLAY.
    collide = 4'b0001; run(DT + IT + 20);
    collide = '0; run(3);

    // Eat ghost 2, then eat ghost 2 while ghost 0 is lethal.
    frightened = 4'b0100; collide = 4'b0100; step();
    collide = '0; step();
    collide = 4'b0101; step();
    collide = '0; frightened = '0; run(DT + IT + 5);

    // Lives now 1: death coincides with bonus crossing.
    collide = 4'b0010; score = 16'(BS); step();
    collide = '0; run(DT + 10);
    score = 16'd0; step();
    score = 16'(BS + 1); step();
    run(IT);

    // Final death, then game over ignores everything.
    die_once();
    for (int i = 0; i < 30; i++) begin
      collide = NG'($urandom_range(15));
      score = 16'($urandom_range(20000));
      step();
    end
    collide = '0;
    do_reset();

    // Bonus at the ceiling saturates; later reset mid-DYING.
    score = 16'd20000; step();
    score = 16'd0; run(3);
    collide = 4'b1000; step();
    collide = '0; run(30);
    do_reset();

    // Randomized play.
    for (int c = 0; c < 20000; c++) begin
      reset = ($urandom_range(1999) == 0);
      tick = 1'($urandom_range(1));
      if ($urandom_range(7) == 0)
        collide = ($urandom_range(3) == 0) ? NG'($urandom_range(15)) : '0;
      if ($urandom_range(63) == 0) frightened = NG'($urandom_range(15));
      if ($urandom_range(127) == 0) begin
        r = $urandom_range(4);
        case (r)
          0: score = 16'd0;
          1: score = 16'(BS - 1);
          2: score = 16'(BS);
          3: score = 16'(BS + 1);
          default: score = 16'($urandom_range(65535));
        endcase
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
